alu_seq_core: RTL and testbench
===============================

# alu_seq_core

Single-clock, width-parametrised successor to the lab ALU top. It holds two operand registers loaded by synchronous enables, which replace the per-register clocks. It also holds the result and flag registers, executes one operation per `start`, and offers an optional iterative multiplier that runs over multiple cycles. It drives `result`/`flags` to the board-level display and LED logic and reports completion through a `busy`/`done` handshake.

## Interface
- `WIDTH`, 32: datapath width. Must be a power of two, at least 4.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `din`  in  WIDTH: operand input from switches.
- `ld_a`  in  1: load `din` into operand register A.
- `ld_b`  in  1: load `din` into operand register B.
- `op`  in  4: operation code, sampled on accepted `start`.
- `start`  in  1: execute request.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; `result`/`flags` updated.
- `result`  out  WIDTH: registered result F.
- `flags`  out  4: registered {ZF, SF, OF, CF}.

## Operation
- Op codes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOR.
  - 6 SLL: A << B[log2(WIDTH)−1:0].
  - 7 SRL.
  - 8 SRA.
  - 9 SLT: signed A<B gives 1, else 0.
  - 10 SLTU: unsigned compare.
  - 11 MUL: low WIDTH bits of unsigned A×B.
  - 12–15: undefined, result 0.
- Flags:
  - ZF = (result == 0).
  - SF = result[WIDTH−1].
  - ADD: CF = carry out; OF = signed overflow.
  - SUB: CF = borrow (A <u B); OF = signed overflow.
  - MUL: CF = OF = (upper WIDTH bits of full product ≠ 0).
  - All other ops: CF = OF = 0.
- FSM states:
  - IDLE: accepts `start`. Ops other than MUL go to IDLE, writing result and flags at the same edge. MUL goes to MUL.
  - MUL: shift-and-add, one multiplier bit per cycle, WIDTH cycles. Counter runs 0..WIDTH−1. After the last iteration, result and flags are written and the FSM returns to IDLE.
- Operands and op are latched at `start` acceptance. A/B changes during MUL do not affect the result.
- `ld_a`/`ld_b` while `busy` are ignored. `start` while `busy` is ignored; it is not queued.
- `ld_a` and `ld_b` in the same cycle both load `din`.
- `ld_x` together with `start` in IDLE: the operation uses the pre-edge register value, and the load still takes effect.
- Reset (all registers): A, B, `result` = 0; `flags` = 4'b0000; `busy` = 0; `done` = 0; FSM = IDLE; counter = 0. Reset during MUL aborts the operation and produces no `done`.

## Timing
- Single-cycle op: `start` sampled at edge t. `result`/`flags` are valid after t, and `done` is high for the cycle t..t+1. `busy` stays 0.
- MUL: `start` at edge t. `busy` is high from t to t+WIDTH. `result`/`flags`/`done` update at edge t+WIDTH, and `busy` falls at that same edge. Latency is WIDTH cycles.
- A new `start` is accepted on the cycle `done` is high, giving back-to-back single-cycle ops at one per clock.
- `result`/`flags` hold their value until the next completion.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state, counter and partial-product logic are present, and op 11 behaves as above.
- `ALU_SEQ_MUL_EN` undefined: no MUL state. Op 11 is treated as undefined: single cycle, result 0, flags 4'b1000. `busy` is tied to 0.

## Test plan
- ADD: A=0x7FFFFFFF, B=0x00000001 → result 0x80000000, flags 4'b0110, `done` one cycle after `start`, `busy` stays 0.
- SUB then SRA: first A=0, B=1 → 0xFFFFFFFF with flags 4'b0101. Then, issued back-to-back, SRA with A=0x80000000, B=4 → 0xF8000000 with flags 4'b0100.
- MUL (macro on): A=0x00010000, B=0x00010000 → result 0, flags 4'b1011. `done` arrives exactly 32 cycles after `start`. A `start` plus `ld_a` at cycle 5 is ignored, and A is unchanged.
- MUL (macro on): A=12345, B=678 → 8369910 (0x007FB6F6), flags 4'b0000. Then `rst_n`=0 at cycle 10 of a second MUL: all outputs go to 0, there is no `done`, and the FSM is in IDLE.
- Op 11 (macro off) and op 14: result 0, flags 4'b1000, single-cycle `done`. `ld_a` with `start` at the same edge (A=5 → 9, B=3, ADD) → result 8, and A reads 9 afterwards.

Source files
------------

// File: rtl/alu_seq_core.sv
// Sequential ALU core: operand/result/flag registers, one operation per start.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-and-add multiplier (op 11).
module alu_seq_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [3:0]       r_flags;
    logic             r_done;

    logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_res_nxt;
    logic [3:0]       w_flags_nxt;
    logic             w_done_nxt;
    logic             w_idle;

    logic [WIDTH:0]   w_sum, w_dif;
    logic [SHW-1:0]   w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_cf, w_alu_of;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0]     OP_MUL   = 4'd11;
    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_MUL   = 1'b1;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [0:0]         r_state, w_state_nxt;
    logic [SHW-1:0]     r_cnt, w_cnt_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt, r_mc, w_mc_nxt, w_acc_step;
    logic [WIDTH-1:0]   r_mp, w_mp_nxt;
    logic               r_busy, w_busy_nxt;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_acc_step = r_mp[0] ? (r_acc + r_mc) : r_acc;
    assign busy       = r_busy;
`else
    assign w_idle = 1'b1;
    assign busy   = 1'b0;
`endif

    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;

    // Single-cycle datapath on the pre-edge operand registers
    always_comb begin
        w_sum     = {1'b0, r_a} + {1'b0, r_b};
        w_dif     = {1'b0, r_a} - {1'b0, r_b};
        w_shamt   = r_b[SHW-1:0];
        w_slt     = ($signed(r_a) < $signed(r_b));
        w_alu_res = '0;
        w_alu_cf  = 1'b0;
        w_alu_of  = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_cf  = w_sum[WIDTH];
                w_alu_of  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_dif[WIDTH-1:0];
                w_alu_cf  = w_dif[WIDTH];
                w_alu_of  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_XOR:  w_alu_res = r_a ^ r_b;
            OP_NOR:  w_alu_res = ~(r_a | r_b);
            OP_SLL:  w_alu_res = r_a << w_shamt;
            OP_SRL:  w_alu_res = r_a >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(r_a) >>> w_shamt);
            OP_SLT:  w_alu_res = WIDTH'(w_slt);
            OP_SLTU: w_alu_res = WIDTH'(w_dif[WIDTH]);
            default: w_alu_res = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_result;
        w_flags_nxt = r_flags;
        w_done_nxt  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_mc_nxt    = r_mc;
        w_mp_nxt    = r_mp;
        w_busy_nxt  = r_busy;
`endif
        if (w_idle) begin
            if (ld_a) w_a_nxt = din;
            if (ld_b) w_b_nxt = din;
            if (start) begin
`ifdef ALU_SEQ_MUL_EN
                if (op == OP_MUL) begin
                    w_state_nxt = ST_MUL;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_mc_nxt    = {WIDTH'(0), r_a};
                    w_mp_nxt    = r_b;
                end else
`endif
                begin
                    w_res_nxt   = w_alu_res;
                    w_flags_nxt = {(w_alu_res == '0), w_alu_res[WIDTH-1], w_alu_of, w_alu_cf};
                    w_done_nxt  = 1'b1;
                end
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else begin
            w_acc_nxt = w_acc_step;
            w_mc_nxt  = r_mc << 1;
            w_mp_nxt  = r_mp >> 1;
            w_cnt_nxt = r_cnt + SHW'(1);
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_cnt_nxt   = '0;
                w_res_nxt   = w_acc_step[WIDTH-1:0];
                w_flags_nxt = {(w_acc_step[WIDTH-1:0] == '0), w_acc_step[WIDTH-1],
                               |w_acc_step[2*WIDTH-1:WIDTH], |w_acc_step[2*WIDTH-1:WIDTH]};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= 4'b0000;
            r_done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mc     <= '0;
            r_mp     <= '0;
            r_busy   <= 1'b0;
`endif
        end else begin
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_result <= w_res_nxt;
            r_flags  <= w_flags_nxt;
            r_done   <= w_done_nxt;
`ifdef ALU_SEQ_MUL_EN
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_mc     <= w_mc_nxt;
            r_mp     <= w_mp_nxt;
            r_busy   <= w_busy_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: vector table plus hand-written back-to-back,
// load/start overlap and (with ALU_SEQ_MUL_EN) multiplier and reset-abort sequences.
module tb_alu_seq_core;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         ld_a = 1'b0, ld_b = 1'b0, start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic         busy, done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .ld_a(ld_a), .ld_b(ld_b),
        .op(op), .start(start), .busy(busy), .done(done),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } vec_t;

    vec_t vecs[20];
    int   nv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk); din = a; ld_a = 1'b1;
        @(negedge clk); ld_a = 1'b0; din = b; ld_b = 1'b1;
        @(negedge clk); ld_b = 1'b0;
    endtask

    // Issue a single-cycle op from the current negedge and check at the start edge
    task automatic run_single(input string name, input logic [3:0] o,
                              input logic [W-1:0] er, input logic [3:0] ef);
        op = o; start = 1'b1;
        @(posedge clk); #1;
        chk({name, "_res"}, 64'(result), 64'(er));
        chk({name, "_flg"}, 64'(flags), 64'(ef));
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk); start = 1'b0;
    endtask

`ifdef ALU_SEQ_MUL_EN
    // Start a MUL and return the number of edges until done (0 on timeout)
    task automatic run_mul(output int lat);
        op = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        chk("mul_busy_hi", 64'(busy), 64'd1);
        chk("mul_done_lo", 64'(done), 64'd0);
        @(negedge clk); start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                @(negedge clk); start = 1'b1; op = 4'd0; ld_a = 1'b1; din = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                @(negedge clk); start = 1'b0; ld_a = 1'b0; op = 4'd11;
            end else begin
                @(posedge clk); #1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask
`endif

    initial begin
        nv = 0;
        vecs[nv++] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  32'h8000_0000, 4'b0110};
        vecs[nv++] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  32'h0000_0000, 4'b1001};
        vecs[nv++] = '{32'h0000_0000, 32'h0000_0001, 4'd1,  32'hFFFF_FFFF, 4'b0101};
        vecs[nv++] = '{32'h8000_0000, 32'h0000_0001, 4'd1,  32'h7FFF_FFFF, 4'b0010};
        vecs[nv++] = '{32'h0000_0005, 32'h0000_0005, 4'd1,  32'h0000_0000, 4'b1000};
        vecs[nv++] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2,  32'hF000_F000, 4'b0100};
        vecs[nv++] = '{32'h0F0F_0000, 32'h0000_00F0, 4'd3,  32'h0F0F_00F0, 4'b0000};
        vecs[nv++] = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 4'd4,  32'h0000_0000, 4'b1000};
        vecs[nv++] = '{32'h0000_0000, 32'h0000_0000, 4'd5,  32'hFFFF_FFFF, 4'b0100};
        vecs[nv++] = '{32'h0000_0001, 32'h0000_0021, 4'd6,  32'h0000_0002, 4'b0000};
        vecs[nv++] = '{32'h8000_0000, 32'h0000_001F, 4'd7,  32'h0000_0001, 4'b0000};
        vecs[nv++] = '{32'h8000_0000, 32'h0000_0004, 4'd8,  32'hF800_0000, 4'b0100};
        vecs[nv++] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd9,  32'h0000_0001, 4'b0000};
        vecs[nv++] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd10, 32'h0000_0000, 4'b1000};
        vecs[nv++] = '{32'h0000_0001, 32'hFFFF_FFFF, 4'd9,  32'h0000_0000, 4'b1000};
        vecs[nv++] = '{32'h0000_0001, 32'hFFFF_FFFF, 4'd10, 32'h0000_0001, 4'b0000};
        vecs[nv++] = '{32'h0000_0005, 32'h0000_0003, 4'd14, 32'h0000_0000, 4'b1000};
`ifndef ALU_SEQ_MUL_EN
        vecs[nv++] = '{32'h0001_0000, 32'h0001_0000, 4'd11, 32'h0000_0000, 4'b1000};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_flg", 64'(flags), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven single-cycle ops, with done falling and result holding afterwards
        for (int i = 0; i < nv; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].res, vecs[i].flg);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_fall", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d_hold", i), 64'(result), 64'(vecs[i].res));
        end

        // Back-to-back: SUB, SRA by 1, SRA by 4, each start overlapping a load
        load_ab(32'h0, 32'h1);
        op = 4'd1; start = 1'b1; ld_a = 1'b1; din = 32'h8000_0000;
        @(posedge clk); #1;
        chk("b2b_sub_res", 64'(result), 64'hFFFF_FFFF);
        chk("b2b_sub_flg", 64'(flags), 64'b0101);
        chk("b2b_sub_done", 64'(done), 64'd1);
        @(negedge clk); op = 4'd8; ld_a = 1'b0; ld_b = 1'b1; din = 32'h4;
        @(posedge clk); #1;
        chk("b2b_sra1_res", 64'(result), 64'hC000_0000);
        chk("b2b_sra1_flg", 64'(flags), 64'b0100);
        chk("b2b_sra1_done", 64'(done), 64'd1);
        @(negedge clk); ld_b = 1'b0;
        @(posedge clk); #1;
        chk("b2b_sra4_res", 64'(result), 64'hF800_0000);
        chk("b2b_sra4_flg", 64'(flags), 64'b0100);
        chk("b2b_sra4_done", 64'(done), 64'd1);
        @(negedge clk); start = 1'b0;

        // Load together with start: ADD uses old A=5, then A=9 is visible
        load_ab(32'd5, 32'd3);
        ld_a = 1'b1; din = 32'd9;
        run_single("ldstart_add", 4'd0, 32'd8, 4'b0000);
        ld_a = 1'b0;
        run_single("ldstart_after", 4'd0, 32'd12, 4'b0000);

`ifdef ALU_SEQ_MUL_EN
        begin
            int lat;
            load_ab(32'h0001_0000, 32'h0001_0000);
            run_mul(lat);
            chk("mul1_latency", 64'(lat), 64'd32);
            chk("mul1_res", 64'(result), 64'd0);
            chk("mul1_flg", 64'(flags), 64'b1011);
            chk("mul1_busy_fall", 64'(busy), 64'd0);
            @(negedge clk);
            run_single("mul1_a_kept", 4'd0, 32'h0002_0000, 4'b0000);

            load_ab(32'd12345, 32'd678);
            run_mul(lat);
            chk("mul2_latency", 64'(lat), 64'd32);
            chk("mul2_res", 64'(result), 64'h007F_B6F6);
            chk("mul2_flg", 64'(flags), 64'b0000);

            // Reset in the middle of a MUL
            @(negedge clk); op = 4'd11; start = 1'b1;
            @(negedge clk); start = 1'b0;
            repeat (9) @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("abort_res", 64'(result), 64'd0);
            chk("abort_flg", 64'(flags), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            @(negedge clk); rst_n = 1'b1;
            lat = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done || busy) lat++;
            end
            chk("abort_no_done", 64'(lat), 64'd0);
            @(negedge clk);
            run_single("abort_idle", 4'd0, 32'd0, 4'b1000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
